regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-read-port integer register file for the core datapath.
//  - Provides 1 write port and NREAD combinational read ports. x0 is hardwired to zero.
//  - Per-register busy scoreboard supports hazard detection.
//  - Sequential soft-clear engine zeroes the array one register per cycle.
//  - Sits between decode (reads, busy set) and writeback (write, busy clear).
// PARAMETERS
//  XLEN   32  data width in bits
//  NREGS  32  number of registers, power of 2, >=4; AW = $clog2(NREGS)
//  NREAD  2   number of read ports, 1..4
// PORTS
//  clk_i       in   1           clock; all state updates on rising edge
//  reset_i     in   1           asynchronous, active-low reset
//  regwrite_i  in   1           writeback enable
//  rd_i        in   AW          writeback destination index
//  wd_i        in   XLEN        writeback data
//  rs_i        in   NREAD*AW    packed read indices; port p = rs_i[p*AW +: AW]
//  operand_o   out  NREAD*XLEN  packed read data; port p = operand_o[p*XLEN +: XLEN]
//  busy_o      out  NREAD       busy bit of register rs_i[p]
//  busy_set_i  in   1           mark busy_rd_i pending (instruction issued)
//  busy_rd_i   in   AW          register to mark pending
//  clear_i     in   1           request soft clear of the whole array
//  ready_o     out  1           1 = IDLE, writes accepted; 0 = clear in progress
// BEHAVIOUR
//  Reset (reset_i=0, async):
//  - All registers = 0, all busy bits = 0, FSM = IDLE, ready_o = 1.
//  - Reset has immediate effect, including mid-clear.
//  Read path: combinational.
//  - operand_o[p] = 0 if rs_i[p]==0, else reg[rs_i[p]].
//  - busy_o[p] = 0 if rs_i[p]==0, else busy[rs_i[p]].
//  Write path (1-cycle latency):
//  - Condition: regwrite_i & ready_o & rd_i!=0.
//  - Effect: reg[rd_i] <= wd_i at the edge, and busy[rd_i] <= 0.
//  - Writes to x0 are dropped. Writes while ready_o=0 are dropped (no buffering).
//  Scoreboard:
//  - busy_set_i & ready_o & busy_rd_i!=0 -> busy[busy_rd_i] <= 1.
//  - Same register set and cleared in one cycle: set wins (newer producer).
//  - Different registers: both updates apply.
//  FSM:
//  - IDLE: on clear_i, go to CLEAR, load idx = 1, clear all busy bits.
//  - CLEAR: reg[idx] <= 0, idx++ each cycle; after idx == NREGS-1 is zeroed, return to IDLE.
//  - CLEAR lasts exactly NREGS-1 cycles; ready_o=0 throughout.
//  - clear_i is ignored in CLEAR. busy_set_i is ignored in CLEAR.
//  - Reads during CLEAR return current contents (partially cleared).
//  - idx counter is AW bits wide and must not wrap past NREGS-1.
// CONFIGURATION
//  RF_BYPASS_EN defined:
//  - Write-through forwarding. If a write qualifies and rd_i==rs_i[p], operand_o[p] = wd_i
//    and busy_o[p] = 0 in the same cycle.
//  - Applies per port, independently.
//  RF_BYPASS_EN undefined:
//  - The read returns the old value until the edge. Decode must stall one cycle.
// TESTING
//  1. Deassert reset; read all ports -> all operand_o = 0, busy_o = 0, ready_o = 1.
//  2. Write rd=5, wd=0xDEADBEEF; next cycle read rs0=5, rs1=0 -> 0xDEADBEEF, 0.
//     Write rd=0, wd=0x1234 -> read x0 = 0.
//  3. busy_set rd=7; next cycle busy_o=1 on rs=7. Same cycle busy_set rd=7 and write rd=7
//     -> busy stays 1. Write rd=7 alone -> busy 0.
//  4. Fill regs 1..31 = index; pulse clear_i -> ready_o=0 for 31 cycles.
//     Write rd=3 mid-clear is dropped. After ready_o=1, all reads return 0.
//  5. Drop reset_i mid-clear (cycle 10) -> ready_o=1 immediately; all regs and busy bits 0.
//  6. RF_BYPASS_EN: write rd=9, wd=0xA5A5A5A5 with rs1=9 in the same cycle
//     -> operand_o[1]=0xA5A5A5A5 combinationally. Without the macro -> old value that cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with busy scoreboard and sequential soft clear.
// Define RF_BYPASS_EN to forward a qualifying write straight to matching read ports.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   regwrite_i,
    input  logic [AW-1:0]          rd_i,
    input  logic [XLEN-1:0]        wd_i,
    input  logic [NREAD*AW-1:0]    rs_i,
    output logic [NREAD*XLEN-1:0]  operand_o,
    output logic [NREAD-1:0]       busy_o,
    input  logic                   busy_set_i,
    input  logic [AW-1:0]          busy_rd_i,
    input  logic                   clear_i,
    output logic                   ready_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic              wr_en;
    logic              set_en;
    logic              clr_start;

    assign ready_o   = (state_q == IDLE);
    assign wr_en     = regwrite_i & ready_o & (rd_i != '0);
    assign set_en    = busy_set_i & ready_o & (busy_rd_i != '0);
    assign clr_start = ready_o & clear_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clear_i) state_d = CLEAR;
            CLEAR:   if (idx == AW'(NREGS-1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // idx stops at NREGS-1; the FSM leaves CLEAR on that same edge
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            idx <= '0;
        end else if (clr_start) begin
            idx <= AW'(1);
        end else if (state_q == CLEAR && idx != AW'(NREGS-1)) begin
            idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                regs[rd_i] <= wd_i;
            end
            if (state_q == CLEAR) begin
                regs[idx] <= '0;
            end
        end
    end

    // Set is applied after clear so an issuing producer wins over a retiring one
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            busy <= '0;
        end else if (clr_start) begin
            busy <= '0;
        end else begin
            if (wr_en) begin
                busy[rd_i] <= 1'b0;
            end
            if (set_en) begin
                busy[busy_rd_i] <= 1'b1;
            end
        end
    end

    always_comb begin
        operand_o = '0;
        busy_o    = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (rs_i[p*AW +: AW] != '0) begin
                operand_o[p*XLEN +: XLEN] = regs[rs_i[p*AW +: AW]];
                busy_o[p]                 = busy[rs_i[p*AW +: AW]];
`ifdef RF_BYPASS_EN
                if (wr_en && rd_i == rs_i[p*AW +: AW]) begin
                    operand_o[p*XLEN +: XLEN] = wd_i;
                    busy_o[p]                 = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed table, clear/reset sequences and
// randomized traffic checked against an array-based reference model.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  clk_i = 1'b0;
    logic                  reset_i = 1'b0;
    logic                  regwrite_i = 1'b0;
    logic [AW-1:0]         rd_i = '0;
    logic [XLEN-1:0]       wd_i = '0;
    logic [AW-1:0]         rs0 = '0;
    logic [AW-1:0]         rs1 = '0;
    logic [NREAD*AW-1:0]   rs_i;
    logic [NREAD*XLEN-1:0] operand_o;
    logic [NREAD-1:0]      busy_o;
    logic                  busy_set_i = 1'b0;
    logic [AW-1:0]         busy_rd_i = '0;
    logic                  clear_i = 1'b0;
    logic                  ready_o;

    assign rs_i = {rs1, rs0};

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .regwrite_i (regwrite_i),
        .rd_i       (rd_i),
        .wd_i       (wd_i),
        .rs_i       (rs_i),
        .operand_o  (operand_o),
        .busy_o     (busy_o),
        .busy_set_i (busy_set_i),
        .busy_rd_i  (busy_rd_i),
        .clear_i    (clear_i),
        .ready_o    (ready_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passed = 0;

    // Reference model: register contents, pending bits, and next register the clear will zero (0 = idle)
    logic [XLEN-1:0] m_reg [NREGS];
    bit              m_busy [NREGS];
    int              m_clr;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_clr = 0;
    endtask

    function automatic bit fwd_hit(input logic [AW-1:0] rs);
`ifdef RF_BYPASS_EN
        return regwrite_i && m_clr == 0 && rd_i != 0 && rd_i == rs;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [XLEN-1:0] exp_op(input logic [AW-1:0] rs);
        if (rs == 0) return '0;
        if (fwd_hit(rs)) return wd_i;
        return m_reg[rs];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] rs);
        if (rs == 0) return 1'b0;
        if (fwd_hit(rs)) return 1'b0;
        return m_busy[rs];
    endfunction

    // Apply the spec rules for the inputs currently driven, then take the clock edge
    task automatic tick();
        bit idle;
        idle = (m_clr == 0);
        if (idle) begin
            if (regwrite_i && rd_i != 0) begin
                m_reg[rd_i]  = wd_i;
                m_busy[rd_i] = 1'b0;
            end
            if (busy_set_i && busy_rd_i != 0) m_busy[busy_rd_i] = 1'b1;
            if (clear_i) begin
                for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
                m_clr = 1;
            end
        end else begin
            m_reg[m_clr] = '0;
            m_clr = (m_clr == NREGS-1) ? 0 : m_clr + 1;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_op0"},  operand_o[XLEN-1:0],      exp_op(rs0));
        check({tag, "_op1"},  operand_o[2*XLEN-1:XLEN], exp_op(rs1));
        check({tag, "_bsy0"}, {31'b0, busy_o[0]},       {31'b0, exp_busy(rs0)});
        check({tag, "_bsy1"}, {31'b0, busy_o[1]},       {31'b0, exp_busy(rs1)});
        check({tag, "_rdy"},  {31'b0, ready_o},         {31'b0, (m_clr == 0)});
    endtask

    typedef struct {
        bit              we;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] wd;
        bit              bs;
        logic [AW-1:0]   brd;
        logic [AW-1:0]   r0;
        logic [AW-1:0]   r1;
        logic [XLEN-1:0] e0;
        logic [XLEN-1:0] e1;
        logic [1:0]      eb;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        model_reset();
        tbl[0] = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00};
        tbl[1] = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00};
        tbl[2] = '{1, 5'd0,  32'h00001234, 0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00};
        tbl[3] = '{0, 5'd0,  32'h0,        1, 5'd7,  5'd7,  5'd5,  32'h0,        32'hDEADBEEF, 2'b01};
        tbl[4] = '{1, 5'd7,  32'h00000077, 1, 5'd7,  5'd7,  5'd0,  32'h00000077, 32'h0,        2'b01};
        tbl[5] = '{1, 5'd7,  32'h00000088, 0, 5'd0,  5'd7,  5'd7,  32'h00000088, 32'h00000088, 2'b00};
        tbl[6] = '{1, 5'd31, 32'hFFFFFFFF, 1, 5'd3,  5'd31, 5'd3,  32'hFFFFFFFF, 32'h0,        2'b10};
        tbl[7] = '{1, 5'd3,  32'h00000033, 1, 5'd31, 5'd3,  5'd31, 32'h00000033, 32'hFFFFFFFF, 2'b10};
        tbl[8] = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd31, 5'd7,  32'hFFFFFFFF, 32'h00000088, 2'b01};

        // Reset state, asynchronous with no clock edge
        #1;
        check("rst_rdy", {31'b0, ready_o}, 32'd1);
        check("rst_op",  operand_o[XLEN-1:0], 32'h0);
        @(negedge clk_i);
        reset_i = 1'b1;
        tick();

        // Directed table
        foreach (tbl[i]) begin
            regwrite_i = tbl[i].we;  rd_i = tbl[i].rd;  wd_i = tbl[i].wd;
            busy_set_i = tbl[i].bs;  busy_rd_i = tbl[i].brd;
            tick();
            regwrite_i = 1'b0;  busy_set_i = 1'b0;
            rs0 = tbl[i].r0;  rs1 = tbl[i].r1;
            #1;
            check($sformatf("tbl%0d_op0", i), operand_o[XLEN-1:0], tbl[i].e0);
            check($sformatf("tbl%0d_op1", i), operand_o[2*XLEN-1:XLEN], tbl[i].e1);
            check($sformatf("tbl%0d_bsy", i), {30'b0, busy_o}, {30'b0, tbl[i].eb});
            check($sformatf("tbl%0d_rdy", i), {31'b0, ready_o}, 32'd1);
        end

        // Fill 1..31 with their index, then soft clear
        for (int r = 1; r < NREGS; r++) begin
            regwrite_i = 1'b1;  rd_i = AW'(r);  wd_i = XLEN'(r);
            tick();
        end
        regwrite_i = 1'b0;
        busy_set_i = 1'b1;  busy_rd_i = 5'd4;
        tick();
        busy_set_i = 1'b0;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        cnt = 0;
        while (ready_o == 1'b0 && cnt < 100) begin
            regwrite_i = (cnt == 5);  rd_i = 5'd3;  wd_i = 32'h00000BAD;
            busy_set_i = (cnt == 5);  busy_rd_i = 5'd3;
            clear_i = (cnt == 7);
            rs0 = AW'($urandom);  rs1 = AW'(cnt + 2);
            #1;
            check_all($sformatf("clr%0d", cnt));
            tick();
            cnt++;
        end
        regwrite_i = 1'b0;  busy_set_i = 1'b0;  clear_i = 1'b0;
        check("clr_len", cnt, 32'd31);
        for (int r = 0; r < NREGS; r += 2) begin
            rs0 = AW'(r);  rs1 = AW'(r + 1);
            #1;
            check($sformatf("after_clr_op_%0d", r), operand_o[XLEN-1:0], 32'h0);
            check($sformatf("after_clr_op_%0d", r + 1), operand_o[2*XLEN-1:XLEN], 32'h0);
            check($sformatf("after_clr_bsy_%0d", r), {30'b0, busy_o}, 32'h0);
        end

        // Reset dropped mid-clear
        for (int r = 1; r < NREGS; r++) begin
            regwrite_i = 1'b1;  rd_i = AW'(r);  wd_i = XLEN'(r * 3 + 1);
            tick();
        end
        regwrite_i = 1'b0;
        busy_set_i = 1'b1;  busy_rd_i = 5'd9;
        tick();
        busy_set_i = 1'b0;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rs0 = 5'd30;  rs1 = 5'd9;
        #1;
        check("midclr_rdy_low", {31'b0, ready_o}, 32'd0);
        check("midclr_op30", operand_o[XLEN-1:0], 32'd91);
        #2;
        reset_i = 1'b0;
        #1;
        model_reset();
        check("arst_rdy", {31'b0, ready_o}, 32'd1);
        check("arst_op30", operand_o[XLEN-1:0], 32'h0);
        check("arst_op9", operand_o[2*XLEN-1:XLEN], 32'h0);
        check("arst_bsy", {30'b0, busy_o}, 32'h0);
        @(negedge clk_i);
        reset_i = 1'b1;
        tick();
        check_all("post_rst");

        // Same-cycle write and read of one register
        regwrite_i = 1'b1;  rd_i = 5'd9;  wd_i = 32'h00000099;
        tick();
        regwrite_i = 1'b0;
        busy_set_i = 1'b1;  busy_rd_i = 5'd9;
        tick();
        busy_set_i = 1'b0;
        regwrite_i = 1'b1;  rd_i = 5'd9;  wd_i = 32'hA5A5A5A5;
        rs0 = 5'd0;  rs1 = 5'd9;
        #1;
`ifdef RF_BYPASS_EN
        check("byp_op1", operand_o[2*XLEN-1:XLEN], 32'hA5A5A5A5);
        check("byp_bsy1", {31'b0, busy_o[1]}, 32'd0);
`else
        check("byp_op1", operand_o[2*XLEN-1:XLEN], 32'h00000099);
        check("byp_bsy1", {31'b0, busy_o[1]}, 32'd1);
`endif
        tick();
        regwrite_i = 1'b0;
        #1;
        check("byp_after_op1", operand_o[2*XLEN-1:XLEN], 32'hA5A5A5A5);
        check("byp_after_bsy1", {31'b0, busy_o[1]}, 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            regwrite_i = ($urandom_range(0, 99) < 60);
            rd_i       = AW'($urandom);
            wd_i       = $urandom;
            clear_i    = ($urandom_range(0, 59) == 0);
            busy_set_i = !clear_i && ($urandom_range(0, 99) < 40);
            busy_rd_i  = AW'($urandom);
            rs0 = ($urandom_range(0, 3) == 0) ? rd_i : AW'($urandom);
            rs1 = ($urandom_range(0, 3) == 0) ? rd_i : AW'($urandom);
            #1;
            check_all($sformatf("rnd%0d", c));
            tick();
        end
        regwrite_i = 1'b0;  busy_set_i = 1'b0;  clear_i = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
